// File: rtl/tmp_readout_if.sv
// Result bus of the temperature readout: signed code, packet counts and
// status flags, transferred to the consumer with a valid/ready handshake.
interface tmp_readout_if #(
    parameter int CNT_W = 10,
    parameter int OUT_W = CNT_W + 1
) ();

    logic signed [OUT_W-1:0] code;
    logic [CNT_W-1:0]        src_cnt;
    logic [CNT_W-1:0]        snk_cnt;
    logic                    sat;
    logic                    code_valid;
    logic                    code_ready;
    logic                    overrun;

    modport master (
        output code,
        output src_cnt,
        output snk_cnt,
        output sat,
        output code_valid,
        output overrun,
        input  code_ready
    );

    modport slave (
        input  code,
        input  src_cnt,
        input  snk_cnt,
        input  sat,
        input  code_valid,
        input  overrun,
        output code_ready
    );

endinterface

// File: rtl/tmp_readout.sv
// Receive side of the temperature-sensor phase controller: counts source and
// sink charge packets per conversion frame and publishes src - snk as a code.
module tmp_readout #(
    parameter int CNT_W = 10,
    parameter int OUT_W = CNT_W + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          PI2,
    input  logic          src_n,
    input  logic          snk,
    input  logic          PA,
    input  logic          PB,
    input  logic          PC,
    input  logic          PD,
    tmp_readout_if.master bus
);

    typedef enum logic [1:0] {
        ARMED,
        ACCUM,
        FINISH,
        WAIT_END
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_nx;

    logic             src_q;
    logic             snk_q;
    logic             src_pkt;
    logic             snk_pkt;
    logic             out_ph;
    logic             pre_ph;

    logic [CNT_W-1:0] src_acc;
    logic [CNT_W-1:0] snk_acc;
    logic             sat_acc;

    logic [CNT_W-1:0] src_up;
    logic [CNT_W-1:0] snk_up;
    logic             sat_up;

    logic [CNT_W-1:0] src_nx;
    logic [CNT_W-1:0] snk_nx;
    logic             sat_nx;
    logic             publish;

    logic [OUT_W-1:0] res;

    // A toggle on either packet line is one packet, but only inside PI2.
    assign src_pkt = (src_n ^ src_q) & PI2;
    assign snk_pkt = (snk ^ snk_q) & PI2;

    assign out_ph = PA & PB & PC & PD;
    assign pre_ph = !PA & PB & PC & PD;

    // Zero-extending both counts first makes the difference exact.
    assign res = OUT_W'({1'b0, src_acc}) - OUT_W'({1'b0, snk_acc});

    // Edge history of the packet lines, tracked in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q <= 1'b0;
            snk_q <= 1'b0;
        end else begin
            src_q <= src_n;
            snk_q <= snk;
        end
    end

    // Saturating increment of both accumulators; a packet lost at the top flags sat.
    always_comb begin
        src_up = src_acc;
        snk_up = snk_acc;
        sat_up = sat_acc;
        if (src_pkt) begin
            if (src_acc == CNT_MAX) begin
                sat_up = 1'b1;
            end else begin
                src_up = src_acc + 1'b1;
            end
        end
        if (snk_pkt) begin
            if (snk_acc == CNT_MAX) begin
                sat_up = 1'b1;
            end else begin
                snk_up = snk_acc + 1'b1;
            end
        end
    end

    // Frame state and accumulator registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ARMED;
            src_acc <= '0;
            snk_acc <= '0;
            sat_acc <= 1'b0;
        end else begin
            state   <= state_nx;
            src_acc <= src_nx;
            snk_acc <= snk_nx;
            sat_acc <= sat_nx;
        end
    end

    // Frame sequencing: arm on PI2, count, close on OUTPUT, abort on PRE.
    always_comb begin
        state_nx = state;
        src_nx   = src_acc;
        snk_nx   = snk_acc;
        sat_nx   = sat_acc;
        publish  = 1'b0;
        unique case (state)
            ARMED: begin
                src_nx = '0;
                snk_nx = '0;
                sat_nx = 1'b0;
                if (PI2) begin
                    state_nx = ACCUM;
                    src_nx   = CNT_W'(src_pkt);
                    snk_nx   = CNT_W'(snk_pkt);
                end
            end
            ACCUM: begin
                if (pre_ph) begin
                    state_nx = ARMED;
                    src_nx   = '0;
                    snk_nx   = '0;
                    sat_nx   = 1'b0;
                end else begin
                    src_nx = src_up;
                    snk_nx = snk_up;
                    sat_nx = sat_up;
                    if (out_ph) begin
                        state_nx = FINISH;
                    end
                end
            end
            FINISH: begin
                publish  = 1'b1;
                state_nx = WAIT_END;
                src_nx   = '0;
                snk_nx   = '0;
                sat_nx   = 1'b0;
            end
            WAIT_END: begin
                src_nx = '0;
                snk_nx = '0;
                sat_nx = 1'b0;
                if (!out_ph) begin
                    if (PI2) begin
                        state_nx = ACCUM;
                        src_nx   = CNT_W'(src_pkt);
                        snk_nx   = CNT_W'(snk_pkt);
                    end else begin
                        state_nx = ARMED;
                    end
                end
            end
            default: begin
                state_nx = ARMED;
                src_nx   = '0;
                snk_nx   = '0;
                sat_nx   = 1'b0;
            end
        endcase
    end

    // Result holding register: load when free or being drained, else flag overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.code       <= '0;
            bus.src_cnt    <= '0;
            bus.snk_cnt    <= '0;
            bus.sat        <= 1'b0;
            bus.code_valid <= 1'b0;
            bus.overrun    <= 1'b0;
        end else if (publish) begin
            if (!bus.code_valid || bus.code_ready) begin
                bus.code       <= $signed(res);
                bus.src_cnt    <= src_acc;
                bus.snk_cnt    <= snk_acc;
                bus.sat        <= sat_acc;
                bus.code_valid <= 1'b1;
            end else begin
                bus.overrun <= 1'b1;
            end
        end else if (bus.code_valid && bus.code_ready) begin
            bus.code_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tmp_readout.sv
// Self-checking bench for tmp_readout: directed frames plus randomized
// frames checked against a per-frame packet-count model.
module tb_tmp_readout;

    localparam int CNT_W   = 4;
    localparam int OUT_W   = CNT_W + 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int BW      = OUT_W + 2 * CNT_W + 1;

    logic clk = 1'b0;
    logic reset;
    logic PI2;
    logic src_n;
    logic snk;
    logic PA;
    logic PB;
    logic PC;
    logic PD;

    tmp_readout_if #(.CNT_W(CNT_W), .OUT_W(OUT_W)) bus ();

    tmp_readout #(.CNT_W(CNT_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .PI2   (PI2),
        .src_n (src_n),
        .snk   (snk),
        .PA    (PA),
        .PB    (PB),
        .PC    (PC),
        .PD    (PD),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    bit exp_valid;
    bit exp_ovr;
    int exp_code;
    int exp_src;
    int exp_snk;
    bit exp_sat;
    bit pub_now;
    int pub_ns;
    int pub_nk;
    bit base_rdy;

    function automatic logic [BW-1:0] exp_bus();
        return {OUT_W'(exp_code), CNT_W'(exp_src), CNT_W'(exp_snk), exp_sat};
    endfunction

    function automatic logic [BW-1:0] got_bus();
        return {bus.code, bus.src_cnt, bus.snk_cnt, bus.sat};
    endfunction

    task automatic model_clear();
        exp_valid = 0;
        exp_ovr   = 0;
        exp_code  = 0;
        exp_src   = 0;
        exp_snk   = 0;
        exp_sat   = 0;
        pub_now   = 0;
    endtask

    // One clock edge; outputs are sampled 1 ns later, model follows the frame result.
    task automatic tick();
        bit consume;
        consume = exp_valid && bus.code_ready;
        @(posedge clk);
        #1;
        if (pub_now) begin
            pub_now = 0;
            if (!exp_valid || bus.code_ready) begin
                exp_src   = (pub_ns > CNT_MAX) ? CNT_MAX : pub_ns;
                exp_snk   = (pub_nk > CNT_MAX) ? CNT_MAX : pub_nk;
                exp_sat   = (pub_ns > CNT_MAX) || (pub_nk > CNT_MAX);
                exp_code  = exp_src - exp_snk;
                exp_valid = 1;
            end else begin
                exp_ovr = 1;
            end
        end else if (consume) begin
            exp_valid = 0;
        end
    endtask

    task automatic idle_ph();
        PA = 1'b1; PB = 1'b0; PC = 1'b0; PD = 1'b0;
    endtask

    task automatic out_ph();
        PA = 1'b1; PB = 1'b1; PC = 1'b1; PD = 1'b1;
    endtask

    task automatic pre_ph();
        PA = 1'b0; PB = 1'b1; PC = 1'b1; PD = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        PI2   = 1'b0;
        idle_ph();
        tick();
        tick();
        reset = 1'b0;
        model_clear();
        tick();
    endtask

    // ns/nk toggles while PI2 is high, randomly interleaved, sometimes together.
    task automatic accumulate(input int ns, input int nk);
        PI2 = 1'b1;
        if (ns == 0 && nk == 0) tick();
        while (ns > 0 || nk > 0) begin
            bit ts;
            bit tk;
            ts = (ns > 0) && ($urandom_range(0, 2) != 0);
            tk = (nk > 0) && ($urandom_range(0, 2) != 0);
            if (!ts && !tk) begin
                if (ns > 0) ts = 1;
                else tk = 1;
            end
            if (ts) begin src_n = ~src_n; ns--; end
            if (tk) begin snk = ~snk; nk--; end
            tick();
        end
    endtask

    // PI2 drops (gated toggles allowed), then the first OUTPUT edge.
    task automatic out_start();
        PI2 = 1'b0;
        if ($urandom_range(0, 1) == 1) src_n = ~src_n;
        if ($urandom_range(0, 1) == 1) snk = ~snk;
        tick();
        out_ph();
        tick();
    endtask

    task automatic publish_edge(input int ns, input int nk, input bit rdy, input int ol);
        if (ol < 2) idle_ph();
        bus.code_ready = rdy;
        pub_now = 1;
        pub_ns  = ns;
        pub_nk  = nk;
        tick();
        bus.code_ready = base_rdy;
    endtask

    task automatic out_end(input int ol);
        for (int i = 2; i < ol; i++) tick();
        idle_ph();
        tick();
        tick();
    endtask

    task automatic full_frame(input int ns, input int nk, input bit rdy, input int ol);
        accumulate(ns, nk);
        out_start();
        publish_edge(ns, nk, rdy, ol);
        out_end(ol);
    endtask

    task automatic drain();
        bus.code_ready = 1'b1;
        tick();
        bus.code_ready = base_rdy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.code_valid !== 1'b0 || bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags valid=%b ovr=%b exp 0 0", bus.code_valid, bus.overrun);
        end
        checks++;
        if (got_bus() !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", got_bus());
        end
        reset = 1'b0;
        model_clear();
        tick();
    endtask

    task automatic test_basic();
        base_rdy = 0;
        bus.code_ready = 1'b0;
        accumulate(5, 3);
        out_start();
        checks++;
        if (bus.code_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early valid=%b exp 0", bus.code_valid);
        end
        publish_edge(5, 3, 0, 4);
        checks++;
        if (bus.code_valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_latency valid=%b exp 1", bus.code_valid);
        end
        checks++;
        if (bus.code !== 5'sd2 || bus.src_cnt !== 4'd5 || bus.snk_cnt !== 4'd3 || bus.sat !== 1'b0) begin
            failures++;
            $display("FAIL basic_result got=%h exp code=2 src=5 snk=3 sat=0", got_bus());
        end
        out_end(4);
        checks++;
        if (bus.code_valid !== 1'b1 || got_bus() !== exp_bus()) begin
            failures++;
            $display("FAIL basic_hold valid=%b got=%h exp=%h", bus.code_valid, got_bus(), exp_bus());
        end
        drain();
        checks++;
        if (bus.code_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_drain valid=%b exp 0", bus.code_valid);
        end
    endtask

    task automatic test_gating();
        PI2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            src_n = ~src_n;
            tick();
        end
        accumulate(2, 0);
        out_start();
        publish_edge(2, 0, 0, 2);
        checks++;
        if (bus.code_valid !== 1'b1 || bus.src_cnt !== 4'd2 || bus.code !== 5'sd2) begin
            failures++;
            $display("FAIL gating valid=%b src=%0d code=%0d exp 1 2 2", bus.code_valid, bus.src_cnt, bus.code);
        end
        out_end(2);
        drain();
    endtask

    task automatic test_backpressure();
        full_frame(1, 0, 0, 3);
        full_frame(0, 3, 0, 3);
        checks++;
        if (bus.code_valid !== 1'b1 || bus.code !== 5'sd1 || bus.overrun !== 1'b1) begin
            failures++;
            $display("FAIL backpressure valid=%b code=%0d ovr=%b exp 1 1 1", bus.code_valid, bus.code, bus.overrun);
        end
        drain();
        checks++;
        if (bus.code_valid !== 1'b0 || bus.overrun !== 1'b1) begin
            failures++;
            $display("FAIL bp_drain valid=%b ovr=%b exp 0 1", bus.code_valid, bus.overrun);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        full_frame(2, 1, 0, 2);
        accumulate(1, 4);
        out_start();
        publish_edge(1, 4, 1, 3);
        checks++;
        if (bus.code_valid !== 1'b1 || bus.code !== -5'sd3 || bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL simultaneous valid=%b code=%0d ovr=%b exp 1 -3 0", bus.code_valid, bus.code, bus.overrun);
        end
        out_end(3);
        drain();
    endtask

    task automatic test_saturation();
        accumulate(20, 1);
        out_start();
        publish_edge(20, 1, 0, 2);
        checks++;
        if (bus.src_cnt !== 4'd15 || bus.snk_cnt !== 4'd1 || bus.code !== 5'sd14 || bus.sat !== 1'b1) begin
            failures++;
            $display("FAIL saturation got=%h exp src=15 snk=1 code=14 sat=1", got_bus());
        end
        out_end(2);
        drain();
    endtask

    task automatic test_abort();
        accumulate(3, 2);
        PI2 = 1'b0;
        pre_ph();
        tick();
        idle_ph();
        tick();
        tick();
        tick();
        checks++;
        if (bus.code_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_novalid valid=%b exp 0", bus.code_valid);
        end
        accumulate(2, 0);
        out_start();
        publish_edge(2, 0, 0, 2);
        checks++;
        if (bus.src_cnt !== 4'd2 || bus.snk_cnt !== 4'd0 || bus.code !== 5'sd2) begin
            failures++;
            $display("FAIL abort_restart got=%h exp src=2 snk=0 code=2", got_bus());
        end
        out_end(2);
        accumulate(4, 4);
        reset = 1'b1;
        tick();
        checks++;
        if (bus.code_valid !== 1'b0 || bus.overrun !== 1'b0 || got_bus() !== '0) begin
            failures++;
            $display("FAIL reset_mid valid=%b ovr=%b got=%h exp all 0", bus.code_valid, bus.overrun, got_bus());
        end
        PI2 = 1'b0;
        tick();
        reset = 1'b0;
        model_clear();
        tick();
        accumulate(1, 2);
        out_start();
        publish_edge(1, 2, 0, 2);
        checks++;
        if (bus.code !== -5'sd1 || bus.src_cnt !== 4'd1 || bus.snk_cnt !== 4'd2) begin
            failures++;
            $display("FAIL reset_discard got=%h exp src=1 snk=2 code=-1", got_bus());
        end
        out_end(2);
        drain();
    endtask

    task automatic test_random();
        for (int f = 0; f < 40; f++) begin
            int ns;
            int nk;
            int ol;
            bit rdy;
            ns = $urandom_range(0, 22);
            nk = $urandom_range(0, 22);
            if (ns == 15) ns = 16;
            if (nk == 15) nk = 16;
            ol = $urandom_range(1, 4);
            rdy = 1'($urandom_range(0, 1));
            base_rdy = 1'($urandom_range(0, 1));
            bus.code_ready = base_rdy;
            PI2 = 1'b0;
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                if ($urandom_range(0, 1) == 1) src_n = ~src_n;
                if ($urandom_range(0, 1) == 1) snk = ~snk;
                tick();
            end
            if ($urandom_range(0, 5) == 0) begin
                accumulate(ns, nk);
                PI2 = 1'b0;
                pre_ph();
                tick();
                idle_ph();
                tick();
                checks++;
                if (bus.code_valid !== exp_valid) begin
                    failures++;
                    $display("FAIL rnd_abort f=%0d valid=%b exp=%b", f, bus.code_valid, exp_valid);
                end
                continue;
            end
            accumulate(ns, nk);
            out_start();
            checks++;
            if (bus.code_valid !== exp_valid) begin
                failures++;
                $display("FAIL rnd_pre f=%0d valid=%b exp=%b", f, bus.code_valid, exp_valid);
            end
            publish_edge(ns, nk, rdy, ol);
            checks++;
            if (bus.code_valid !== exp_valid || bus.overrun !== exp_ovr) begin
                failures++;
                $display("FAIL rnd_flags f=%0d valid=%b ovr=%b exp %b %b", f, bus.code_valid, bus.overrun, exp_valid, exp_ovr);
            end
            checks++;
            if (got_bus() !== exp_bus()) begin
                failures++;
                $display("FAIL rnd_data f=%0d got=%h exp=%h", f, got_bus(), exp_bus());
            end
            out_end(ol);
        end
        base_rdy = 0;
        bus.code_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        PI2 = 1'b0;
        src_n = 1'b0;
        snk = 1'b0;
        idle_ph();
        bus.code_ready = 1'b0;
        base_rdy = 0;
        model_clear();
        test_reset();
        test_basic();
        test_gating();
        test_backpressure();
        test_simultaneous();
        test_saturation();
        test_abort();
        do_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
